// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory access sequencer: FSM states, requester ids,
// one-hot grant codes and the latched transaction record.
package mem_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ADDR    = 3'd1;
    localparam state_t ST_WDATA   = 3'd2;
    localparam state_t ST_MEMRD   = 3'd3;
    localparam state_t ST_MEMWR   = 3'd4;
    localparam state_t ST_CAPTURE = 3'd5;
    localparam state_t ST_ACK     = 3'd6;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_FETCH = 2'b01;
    localparam logic [1:0] GNT_DATA  = 2'b10;

    // who: requester id of the current winner; we: store (fetches are always loads)
    typedef struct packed {
        logic who;
        logic we;
    } xact_t;

    function automatic logic [1:0] grant_onehot(input logic who);
        return (who == REQ_DATA) ? GNT_DATA : GNT_FETCH;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational winner, last_grant flop updated by load.
// With both requests present the requester not served last wins.
module rr_arbiter2
    import mem_seq_pkg::*;
(
    input  logic clock,
    input  logic clear,
    input  logic req_fetch,
    input  logic req_data,
    input  logic load,
    output logic winner
);

    logic last_grant;

    always_ff @(posedge clock) begin
        if (clear) begin
            last_grant <= REQ_DATA;
        end else if (load) begin
            last_grant <= winner;
        end
    end

    always_comb begin
        if (req_fetch && req_data) begin
            winner = ~last_grant;
        end else if (req_data) begin
            winner = REQ_DATA;
        end else begin
            winner = REQ_FETCH;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: arbitrates fetch/data requesters and pulses MAR/MDR/RAM strobes.
// Defining MEM_SEQ_ACCESS_CNT_EN adds saturating completed-read/write counters.
//
// state   | meaning
// IDLE    | no transaction; requests sampled every edge
// ADDR    | winner drives address, MAR loads
// WDATA   | data winner drives store data, MDR loads from bus
// MEMRD   | RAM read strobe for MEM_LAT cycles
// MEMWR   | RAM write strobe for MEM_LAT cycles
// CAPTURE | MDR loads from RAM data
// ACK     | one-cycle completion pulse to the winner
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             fetch_req,
    input  logic             data_req,
    input  logic             data_we,
    output logic [1:0]       grant,
    output logic             bus_phase,
    output logic             MARin,
    output logic             MDRin,
    output logic             read,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             fetch_ack,
    output logic             data_ack,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t     state;
    xact_t      xact;
    logic [3:0] wait_cnt;
    logic       any_req;
    logic       winner;
    logic       arb_load;

    assign any_req  = fetch_req | data_req;
    assign arb_load = (state == ST_IDLE) && any_req;

    rr_arbiter2 u_arb (
        .clock     (clock),
        .clear     (clear),
        .req_fetch (fetch_req),
        .req_data  (data_req),
        .load      (arb_load),
        .winner    (winner)
    );

    // wait_cnt counts down to zero; the strobe state lasts MEM_LAT cycles
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= ST_IDLE;
            xact     <= '0;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        xact.who <= winner;
                        xact.we  <= (winner == REQ_DATA) && data_we;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    wait_cnt <= LAT_LOAD;
                    state    <= xact.we ? ST_WDATA : ST_MEMRD;
                end
                ST_WDATA: begin
                    state <= ST_MEMWR;
                end
                ST_MEMRD: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_MEMWR: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        grant     = GNT_NONE;
        bus_phase = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        read      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        fetch_ack = 1'b0;
        data_ack  = 1'b0;
        case (state)
            ST_ADDR: begin
                grant = grant_onehot(xact.who);
                MARin = 1'b1;
            end
            ST_WDATA: begin
                grant     = grant_onehot(xact.who);
                bus_phase = 1'b1;
                MDRin     = 1'b1;
            end
            ST_MEMRD: begin
                mem_rd = 1'b1;
            end
            ST_MEMWR: begin
                mem_wr = 1'b1;
            end
            ST_CAPTURE: begin
                MDRin = 1'b1;
                read  = 1'b1;
            end
            ST_ACK: begin
                fetch_ack = (xact.who == REQ_FETCH);
                data_ack  = (xact.who == REQ_DATA);
            end
            default: begin
            end
        endcase
        busy = (state != ST_IDLE);
    end

`ifdef MEM_SEQ_ACCESS_CNT_EN
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    // ACK reached through MEMWR is a write, through CAPTURE a read
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (state == ST_ACK) begin
            if (xact.we) begin
                if (wr_cnt != {CNT_W{1'b1}}) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end else begin
                if (rd_cnt != {CNT_W{1'b1}}) begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rd_count = rd_cnt;
    assign wr_count = wr_cnt;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: per-cycle schedule model, small MAR/MDR/RAM datapath,
// directed literal checks and a randomized two-requester run.
module tb_mem_access_sequencer;

    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MEM_SEQ_ACCESS_CNT_EN
    localparam int EXP_RD3 = 3;
    localparam int EXP_WR2 = 2;
`else
    localparam int EXP_RD3 = 0;
    localparam int EXP_WR2 = 0;
`endif

    logic             clock = 1'b0;
    logic             clear;
    logic             fetch_req;
    logic             data_req;
    logic             data_we;
    logic [1:0]       grant;
    logic             bus_phase;
    logic             MARin;
    logic             MDRin;
    logic             read;
    logic             mem_rd;
    logic             mem_wr;
    logic             fetch_ack;
    logic             data_ack;
    logic             busy;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;

    always #5 clock = ~clock;

    mem_access_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .clear     (clear),
        .fetch_req (fetch_req),
        .data_req  (data_req),
        .data_we   (data_we),
        .grant     (grant),
        .bus_phase (bus_phase),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .read      (read),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .fetch_ack (fetch_ack),
        .data_ack  (data_ack),
        .busy      (busy),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [10:0] outv();
        return {grant, bus_phase, MARin, MDRin, read, mem_rd, mem_wr, fetch_ack, data_ack, busy};
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h40) return 32'h12345678;
        return (32'(i) * 32'h01000193) ^ 32'h5A5A0000;
    endfunction

    // ---------------- requester side datapath: bus, MAR, MDR, RAM ----------------
    logic [31:0] fetch_addr, data_addr, data_wdata, bus, mar, mdr;
    logic [31:0] ram [0:255];
    logic [31:0] sh  [0:255];
    bit          ram_ready = 1'b0;

    always_comb begin
        bus = 32'h0;
        if (grant == 2'b01) bus = fetch_addr;
        else if (grant == 2'b10) bus = bus_phase ? data_wdata : data_addr;
    end

    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            if (MARin) mar <= bus;
            if (MDRin) mdr <= read ? ram[mar[7:0]] : bus;
            if (mem_wr) ram[mar[7:0]] <= mdr;
        end
    end

    // ---------------- behavioural model: per-cycle output schedule ----------------
    typedef struct packed {
        logic [1:0] grant;
        logic       bus_phase;
        logic       marin;
        logic       mdrin;
        logic       rd_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       fetch_ack;
        logic       data_ack;
        logic       busy;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  wr;
    } entry_t;

    entry_t sched [$];
    entry_t cur;
    logic   m_last;
    int     exp_rd = 0;
    int     exp_wr = 0;
    bit     m_valid = 1'b0;

    // one transaction: address, [store data], MEM_LAT strobes, [capture], ack, one idle
    task automatic plan(input logic who, input logic we);
        entry_t     e;
        logic [1:0] g;
        g = who ? 2'b10 : 2'b01;
        e = '0; e.wr = we; e.o.busy = 1'b1; e.o.grant = g; e.o.marin = 1'b1;
        sched.push_back(e);
        if (we) begin
            e.o = '0; e.o.busy = 1'b1; e.o.grant = g; e.o.bus_phase = 1'b1; e.o.mdrin = 1'b1;
            sched.push_back(e);
            for (int k = 0; k < MEM_LAT; k++) begin
                e.o = '0; e.o.busy = 1'b1; e.o.mem_wr = 1'b1;
                sched.push_back(e);
            end
        end else begin
            for (int k = 0; k < MEM_LAT; k++) begin
                e.o = '0; e.o.busy = 1'b1; e.o.mem_rd = 1'b1;
                sched.push_back(e);
            end
            e.o = '0; e.o.busy = 1'b1; e.o.mdrin = 1'b1; e.o.rd_sel = 1'b1;
            sched.push_back(e);
        end
        e.o = '0; e.o.busy = 1'b1;
        if (who) e.o.data_ack = 1'b1; else e.o.fetch_ack = 1'b1;
        sched.push_back(e);
        e = '0;
        sched.push_back(e);
    endtask

    always @(posedge clock) begin
        logic who;
        if (clear) begin
            sched.delete();
            cur     = '0;
            m_last  = 1'b1;
            exp_rd  = 0;
            exp_wr  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
`ifdef MEM_SEQ_ACCESS_CNT_EN
            if (cur.o.fetch_ack || cur.o.data_ack) begin
                if (cur.wr) begin
                    if (exp_wr < CNT_MAX) exp_wr = exp_wr + 1;
                end else begin
                    if (exp_rd < CNT_MAX) exp_rd = exp_rd + 1;
                end
            end
`endif
            if (sched.size() == 0 && (fetch_req || data_req)) begin
                who    = (fetch_req && data_req) ? ~m_last : data_req;
                m_last = who;
                plan(who, who && data_we);
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = '0;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("outputs", 64'(outv()), 64'(cur.o));
            chk("rd_count", 64'(rd_count), 64'(exp_rd));
            chk("wr_count", 64'(wr_count), 64'(exp_wr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clock);
        clear = 1'b1; fetch_req = 1'b0; data_req = 1'b0;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic txn(input logic is_data, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit drop_mid, input bit toggle_we,
                       output int t_mar, output int t_ack, output int t_rd1, output int n_rd,
                       output int t_cap, output int n_wr);
        int n_ack;
        t_mar = -1; t_ack = -1; t_rd1 = -1; n_rd = 0; t_cap = -1; n_wr = 0; n_ack = 0;
        @(negedge clock);
        if (is_data) begin
            data_addr = addr; data_wdata = wd; data_we = we; data_req = 1'b1;
        end else begin
            fetch_addr = addr; fetch_req = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (MARin && t_mar < 0) t_mar = cyc;
            if (mem_rd) begin
                if (t_rd1 < 0) t_rd1 = cyc;
                n_rd++;
                if (drop_mid) begin data_req = 1'b0; fetch_req = 1'b0; end
            end
            if (mem_wr) n_wr++;
            if (MDRin && read && t_cap < 0) t_cap = cyc;
            if (toggle_we && t_mar >= 0) data_we = ~data_we;
            if (is_data ? data_ack : fetch_ack) begin
                n_ack++;
                if (t_ack < 0) t_ack = cyc;
                data_req = 1'b0; fetch_req = 1'b0;
            end
        end
        chk("ack_count", 64'(n_ack), 64'(1));
        if (is_data && we) begin
            chk("ram_written", 64'(ram[addr[7:0]]), 64'(wd));
            sh[addr[7:0]] = wd;
        end else begin
            chk("mdr_read", 64'(mdr), 64'(sh[addr[7:0]]));
        end
    endtask

    initial begin
        int         t_mar, t_ack, t_rd1, n_rd, t_cap, n_wr;
        int         na, ng, n_reads, f_wait, d_wait;
        logic [1:0] g [0:7];
        bit         seen, f_out, d_out;
        logic       d_lat_we;

        clear = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = '0; data_addr = '0; data_wdata = '0;
        for (int i = 0; i < 256; i++) sh[i] = init_word(i);
        repeat (2) @(negedge clock);
        clear = 1'b0;

        repeat (10) begin
            @(negedge clock);
            chk("idle_outputs_zero", 64'(outv()), 64'(0));
        end

        // clear during MEMRD aborts with no ack
        fetch_addr = 32'h10; fetch_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (mem_rd) seen = 1'b1;
        end
        chk("memrd_reached", 64'(seen), 64'(1));
        clear = 1'b1; fetch_req = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        chk("after_clear_idle", 64'(outv()), 64'(0));
        na = 0;
        repeat (8) begin
            @(negedge clock);
            if (fetch_ack || data_ack) na++;
        end
        chk("no_ack_after_clear", 64'(na), 64'(0));

        do_reset();
        txn(1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, t_mar, t_ack, t_rd1, n_rd, t_cap, n_wr);
        chk("fetch_rd_start", 64'(t_rd1 - t_mar), 64'(1));
        chk("fetch_rd_cycles", 64'(n_rd), 64'(2));
        chk("fetch_capture", 64'(t_cap - t_mar), 64'(3));
        chk("fetch_ack_latency", 64'(t_ack - t_mar), 64'(4));
        chk("fetch_mdr_literal", 64'(mdr), 64'(32'h12345678));

        txn(1'b1, 1'b1, 32'h55, 32'h87654321, 1'b0, 1'b0, t_mar, t_ack, t_rd1, n_rd, t_cap, n_wr);
        chk("store_wr_cycles", 64'(n_wr), 64'(2));
        chk("store_ack_latency", 64'(t_ack - t_mar), 64'(4));
        chk("store_ram_literal", 64'(ram[8'h55]), 64'(32'h87654321));

        txn(1'b1, 1'b0, 32'h23, 32'h0, 1'b1, 1'b1, t_mar, t_ack, t_rd1, n_rd, t_cap, n_wr);
        chk("drop_load_no_write", 64'(n_wr), 64'(0));

        txn(1'b1, 1'b1, 32'h24, 32'hCAFE0024, 1'b0, 1'b1, t_mar, t_ack, t_rd1, n_rd, t_cap, n_wr);
        chk("toggle_store_no_read", 64'(n_rd), 64'(0));

        txn(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, t_mar, t_ack, t_rd1, n_rd, t_cap, n_wr);
        chk("rd_count_3", 64'(rd_count), 64'(EXP_RD3));
        chk("wr_count_2", 64'(wr_count), 64'(EXP_WR2));

        // both requesters held continuously: grants must alternate
        do_reset();
        data_we = 1'b0; fetch_addr = 32'h31; data_addr = 32'h32;
        fetch_req = 1'b1; data_req = 1'b1;
        na = 0; ng = 0;
        for (int k = 0; k < 60 && na < 4; k++) begin
            @(negedge clock);
            if (MARin && ng < 8) begin g[ng] = grant; ng++; end
            if (fetch_ack || data_ack) na++;
        end
        fetch_req = 1'b0; data_req = 1'b0;
        chk("held_acks", 64'(na), 64'(4));
        chk("held_grants", 64'(ng), 64'(4));
        for (int k = 1; k < 4 && k < ng; k++) begin
            chk("held_alternate", 64'(g[k]), 64'({g[k-1][0], g[k-1][1]}));
        end

        // randomized run with both requesters
        do_reset();
        n_reads = 0; f_wait = 0; d_wait = 0; f_out = 1'b0; d_out = 1'b0; d_lat_we = 1'b0;
        repeat (2500) begin
            @(negedge clock);
            if (fetch_ack) begin
                chk("rnd_fetch_mdr", 64'(mdr), 64'(sh[fetch_addr[7:0]]));
                fetch_req = 1'b0; f_out = 1'b0; n_reads++;
            end else if (grant == 2'b01) begin
                f_out = 1'b1;
            end else if (f_out && fetch_req && $urandom_range(7) == 0) begin
                fetch_req = 1'b0;
            end else if (!f_out && !fetch_req && $urandom_range(3) == 0) begin
                fetch_addr = 32'($urandom_range(255)); fetch_req = 1'b1; f_wait = 0;
            end
            if (fetch_req && !f_out) begin
                f_wait++;
                if (f_wait > 30) begin
                    chk("fetch_grant_timeout", 64'(f_wait), 64'(30));
                    fetch_req = 1'b0; f_wait = 0;
                end
            end

            if (data_ack) begin
                if (d_lat_we) begin
                    chk("rnd_store_ram", 64'(ram[data_addr[7:0]]), 64'(data_wdata));
                    sh[data_addr[7:0]] = data_wdata;
                end else begin
                    chk("rnd_load_mdr", 64'(mdr), 64'(sh[data_addr[7:0]]));
                    n_reads++;
                end
                data_req = 1'b0; d_out = 1'b0;
            end else if (grant == 2'b10) begin
                d_out = 1'b1;
            end else if (d_out && data_req && $urandom_range(7) == 0) begin
                data_req = 1'b0;
            end else if (!d_out && !data_req && $urandom_range(3) == 0) begin
                data_addr  = 32'($urandom_range(255));
                data_wdata = $urandom;
                data_we    = 1'($urandom_range(1));
                d_lat_we   = data_we;
                data_req   = 1'b1; d_wait = 0;
            end
            if (d_out && $urandom_range(1) == 1) data_we = ~data_we;
            if (data_req && !d_out) begin
                d_wait++;
                if (d_wait > 30) begin
                    chk("data_grant_timeout", 64'(d_wait), 64'(30));
                    data_req = 1'b0; d_wait = 0;
                end
            end
        end
        fetch_req = 1'b0; data_req = 1'b0;
        repeat (10) @(negedge clock);
`ifdef MEM_SEQ_ACCESS_CNT_EN
        if (n_reads >= CNT_MAX) chk("rd_count_saturated", 64'(rd_count), 64'(CNT_MAX));
`else
        chk("rd_count_tied_zero", 64'(rd_count), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
